// File: rtl/mbus_wire_rx_monitor_if.sv
// Bus-side signal bundle for the MBus input wire monitor.
// "master" is the side that drives the ring wires, EN and WAKE_ACK
// (upstream node / sleep controller / testbench); "slave" is the monitor itself.
interface mbus_wire_rx_monitor_if;
    logic       EN;
    logic       DIN;
    logic       CLKIN;
    logic       WAKE_ACK;
    logic       DIN_F;
    logic       CLKIN_F;
    logic       REQ_DET;
    logic       TXN_DONE;
    logic       BUS_BUSY;
    logic [7:0] EDGE_CNT;
    logic       WAKE_REQ;

    modport master (
        output EN,
        output DIN,
        output CLKIN,
        output WAKE_ACK,
        input  DIN_F,
        input  CLKIN_F,
        input  REQ_DET,
        input  TXN_DONE,
        input  BUS_BUSY,
        input  EDGE_CNT,
        input  WAKE_REQ
    );

    modport slave (
        input  EN,
        input  DIN,
        input  CLKIN,
        input  WAKE_ACK,
        output DIN_F,
        output CLKIN_F,
        output REQ_DET,
        output TXN_DONE,
        output BUS_BUSY,
        output EDGE_CNT,
        output WAKE_REQ
    );
endinterface

// File: rtl/mbus_wire_rx_monitor.sv
// MBus input wire monitor.
// Synchronises and glitch-filters the incoming DIN/CLKIN ring wires, detects a
// bus request (DIN falling while CLKIN is high on an idle bus), counts CLKIN
// falling edges through the transaction, flags the end of a transaction after
// a sustained idle-high bus, and drives a four-phase wake-up request.
module mbus_wire_rx_monitor #(
    parameter int SYNC_STAGES  = 2,   // synchroniser depth per wire, >= 2
    parameter int FILT_LEN     = 3,   // cycles of disagreement before filter update, >= 1
    parameter int IDLE_TIMEOUT = 64   // idle-high cycles that end a transaction, 2..255
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    mbus_wire_rx_monitor_if.slave   bus
);

    // Filter counter only ever holds 0..FILT_LEN-1.
    localparam int FCW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

    localparam int W_DIN   = 0;
    localparam int W_CLKIN = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARB    = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser + glitch filter, one identical lane per wire
    // ------------------------------------------------------------------
    logic [1:0] wire_raw;
    logic [1:0] wire_filt;

    assign wire_raw = {bus.CLKIN, bus.DIN};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wire
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [FCW-1:0]         filt_cnt_reg;
            logic                   filt_reg;
            logic                   sync_out;

            assign sync_out = sync_reg[SYNC_STAGES-1];

            // Shift the raw wire through the synchroniser; the filtered value only
            // follows once the synchronised value has disagreed for FILT_LEN cycles.
            always_ff @(posedge CLK) begin
                if (!RESETn) begin
                    sync_reg     <= '1;
                    filt_cnt_reg <= '0;
                    filt_reg     <= 1'b1;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], wire_raw[gi]};
                    if (sync_out == filt_reg) begin
                        filt_cnt_reg <= '0;
                    end else if (filt_cnt_reg == FCW'(FILT_LEN - 1)) begin
                        filt_reg     <= sync_out;
                        filt_cnt_reg <= '0;
                    end else begin
                        filt_cnt_reg <= filt_cnt_reg + 1'b1;
                    end
                end
            end

            assign wire_filt[gi] = filt_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Edge detection on the filtered wires
    // ------------------------------------------------------------------
    logic [1:0] wire_prev_reg;
    logic [1:0] wire_fall;
    logic [1:0] wire_rise;

    // Remember last cycle's filtered levels; idle-high matches the reset value.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            wire_prev_reg <= 2'b11;
        end else begin
            wire_prev_reg <= wire_filt;
        end
    end

    assign wire_fall = wire_prev_reg & ~wire_filt;
    assign wire_rise = ~wire_prev_reg & wire_filt;

    logic din_f;
    logic clkin_f;
    logic din_fall;
    logic clkin_fall;
    logic idle_cycle;

    assign din_f      = wire_filt[W_DIN];
    assign clkin_f    = wire_filt[W_CLKIN];
    assign din_fall   = wire_fall[W_DIN];
    assign clkin_fall = wire_fall[W_CLKIN];

    // A cycle counts towards the idle timeout only when both wires sit high
    // and nothing moved on either wire.
    assign idle_cycle = din_f & clkin_f & ~(|wire_fall) & ~(|wire_rise);

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    state_t     state_reg,    state_next;
    logic       req_det_reg,  req_det_next;
    logic       txn_done_reg, txn_done_next;
    logic       busy_reg;
    logic [7:0] edge_cnt_reg, edge_cnt_next;
    logic [7:0] idle_cnt_reg, idle_cnt_next;
    logic [7:0] idle_inc;
    logic       idle_expired;

    assign idle_inc     = idle_cnt_reg + 8'd1;
    assign idle_expired = idle_cycle && (idle_inc == 8'(IDLE_TIMEOUT));

    // Next-state, pulse and counter logic; EN low parks the FSM in IDLE
    // without generating pulses and keeps the last edge count visible.
    always_comb begin
        state_next    = state_reg;
        req_det_next  = 1'b0;
        txn_done_next = 1'b0;
        edge_cnt_next = edge_cnt_reg;
        idle_cnt_next = 8'd0;

        if (!bus.EN) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // A DIN fall with CLKIN low is not an arbitration start.
                    if (din_fall && clkin_f) begin
                        req_det_next  = 1'b1;
                        edge_cnt_next = 8'd0;
                        state_next    = ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (clkin_fall) begin
                        edge_cnt_next = 8'd1;
                        state_next    = ST_ACTIVE;
                    end else if (idle_expired) begin
                        // Nobody clocked the bus: spurious request, silent return.
                        state_next = ST_IDLE;
                    end else if (idle_cycle) begin
                        idle_cnt_next = idle_inc;
                    end
                end
                ST_ACTIVE: begin
                    if (clkin_fall && (edge_cnt_reg != 8'hFF)) begin
                        edge_cnt_next = edge_cnt_reg + 8'd1;
                    end
                    if (idle_expired) begin
                        txn_done_next = 1'b1;
                        state_next    = ST_IDLE;
                    end else if (idle_cycle) begin
                        idle_cnt_next = idle_inc;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state and registered outputs. BUS_BUSY is a registered copy of the
    // current state, so it drops the cycle after TXN_DONE.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_reg    <= ST_IDLE;
            req_det_reg  <= 1'b0;
            txn_done_reg <= 1'b0;
            busy_reg     <= 1'b0;
            edge_cnt_reg <= 8'd0;
            idle_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            req_det_reg  <= req_det_next;
            txn_done_reg <= txn_done_next;
            busy_reg     <= (state_reg != ST_IDLE);
            edge_cnt_reg <= edge_cnt_next;
            idle_cnt_reg <= idle_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Four-phase wake handshake
    // ------------------------------------------------------------------
    logic wake_req_reg,  wake_req_next;
    logic wake_pend_reg, wake_pend_next;
    logic wake_clear;

    assign wake_clear = wake_req_reg & bus.WAKE_ACK;

    // Raise WAKE_REQ alongside REQ_DET when the channel is free; otherwise park
    // the request in the pending bit so it is replayed once WAKE_ACK drops.
    always_comb begin
        wake_req_next  = wake_req_reg;
        wake_pend_next = wake_pend_reg;

        if (wake_clear) begin
            wake_req_next = 1'b0;
            if (req_det_next) begin
                wake_pend_next = 1'b1;
            end
        end else if (!bus.WAKE_ACK && (wake_pend_reg || (req_det_next && !wake_req_reg))) begin
            wake_req_next  = 1'b1;
            wake_pend_next = 1'b0;
        end else if (req_det_next && bus.WAKE_ACK) begin
            wake_pend_next = 1'b1;
        end
    end

    // Wake handshake registers.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            wake_req_reg  <= 1'b0;
            wake_pend_reg <= 1'b0;
        end else begin
            wake_req_reg  <= wake_req_next;
            wake_pend_reg <= wake_pend_next;
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign bus.DIN_F    = din_f;
    assign bus.CLKIN_F  = clkin_f;
    assign bus.REQ_DET  = req_det_reg;
    assign bus.TXN_DONE = txn_done_reg;
    assign bus.BUS_BUSY = busy_reg;
    assign bus.EDGE_CNT = edge_cnt_reg;
    assign bus.WAKE_REQ = wake_req_reg;

endmodule

// File: tb/tb_mbus_wire_rx_monitor.sv
// Directed testbench for mbus_wire_rx_monitor (default parameters).
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_mbus_wire_rx_monitor;

    logic clk;
    logic resetn;

    mbus_wire_rx_monitor_if bus();

    mbus_wire_rx_monitor dut (
        .CLK    (clk),
        .RESETn (resetn),
        .bus    (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int req_cnt     = 0;
    int done_cnt    = 0;
    int cyc         = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and pulse counters (sampled shortly after each rising edge).
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (bus.REQ_DET === 1'b1)  req_cnt  = req_cnt + 1;
        if (bus.TXN_DONE === 1'b1) done_cnt = done_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers (stimulus / bounded waits only) ----------------
    task automatic wait_req(output int lat);
        lat = 0;
        while (bus.REQ_DET !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.TXN_DONE !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_not_busy(output int lat);
        lat = 0;
        while (bus.BUS_BUSY !== 1'b0 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_din_f_high(output int lat);
        lat = 0;
        while (bus.DIN_F !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic clk_periods(input int n, input int lo, input int hi);
        for (int i = 0; i < n; i++) begin
            bus.CLKIN = 1'b0;
            repeat (lo) @(negedge clk);
            bus.CLKIN = 1'b1;
            repeat (hi) @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn       = 1'b0;
        bus.EN       = 1'b1;
        bus.DIN      = 1'b1;
        bus.CLKIN    = 1'b1;
        bus.WAKE_ACK = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        vectors++; if (bus.DIN_F !== 1'b1) begin miscompares++; $display("FAIL reset_din_f: got %b expected 1", bus.DIN_F); end
        vectors++; if (bus.CLKIN_F !== 1'b1) begin miscompares++; $display("FAIL reset_clkin_f: got %b expected 1", bus.CLKIN_F); end
        vectors++; if (bus.REQ_DET !== 1'b0) begin miscompares++; $display("FAIL reset_req_det: got %b expected 0", bus.REQ_DET); end
        vectors++; if (bus.TXN_DONE !== 1'b0) begin miscompares++; $display("FAIL reset_txn_done: got %b expected 0", bus.TXN_DONE); end
        vectors++; if (bus.BUS_BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.BUS_BUSY); end
        vectors++; if (bus.EDGE_CNT !== 8'd0) begin miscompares++; $display("FAIL reset_edge_cnt: got %0d expected 0", bus.EDGE_CNT); end
        vectors++; if (bus.WAKE_REQ !== 1'b0) begin miscompares++; $display("FAIL reset_wake_req: got %b expected 0", bus.WAKE_REQ); end
        repeat (200) @(negedge clk);
        vectors++; if (req_cnt !== 0) begin miscompares++; $display("FAIL idle_req_pulses: got %0d expected 0", req_cnt); end
        vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL idle_done_pulses: got %0d expected 0", done_cnt); end
        vectors++; if (bus.BUS_BUSY !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b expected 0", bus.BUS_BUSY); end
        $display("reset/idle: 200 quiet cycles, req=%0d done=%0d", req_cnt, done_cnt);
    endtask

    task automatic test_glitch();
        int r0, d0, t, lat;
        bit low_seen;
        r0 = req_cnt;
        d0 = done_cnt;
        // Two-cycle glitch on DIN.
        bus.DIN = 1'b0;
        repeat (2) @(negedge clk);
        bus.DIN = 1'b1;
        low_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.DIN_F !== 1'b1) low_seen = 1'b1;
        end
        vectors++; if (low_seen !== 1'b0) begin miscompares++; $display("FAIL glitch_din_f: got low seen expected DIN_F held 1"); end
        vectors++; if (req_cnt !== r0) begin miscompares++; $display("FAIL glitch_req: got %0d pulses expected 0", req_cnt - r0); end
        $display("glitch: 2-cycle DIN pulse rejected=%0d", !low_seen);
        // Ten-cycle low: DIN_F follows SYNC_STAGES+FILT_LEN = 5 cycles later.
        bus.DIN = 1'b0;
        t = 0;
        while (bus.DIN_F !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        vectors++; if (t !== 5) begin miscompares++; $display("FAIL din_f_latency: got %0d expected 5", t); end
        @(negedge clk);
        vectors++; if (bus.REQ_DET !== 1'b1) begin miscompares++; $display("FAIL req_det_pulse: got %b expected 1", bus.REQ_DET); end
        vectors++; if (bus.WAKE_REQ !== 1'b1) begin miscompares++; $display("FAIL wake_req_with_req: got %b expected 1", bus.WAKE_REQ); end
        @(negedge clk);
        vectors++; if (bus.REQ_DET !== 1'b0) begin miscompares++; $display("FAIL req_det_one_cycle: got %b expected 0", bus.REQ_DET); end
        vectors++; if (bus.BUS_BUSY !== 1'b1) begin miscompares++; $display("FAIL busy_after_req: got %b expected 1", bus.BUS_BUSY); end
        repeat (3) @(negedge clk);
        bus.DIN = 1'b1;
        wait_not_busy(lat);
        vectors++; if (lat >= 200) begin miscompares++; $display("FAIL glitch_return_idle: got busy after %0d cycles expected idle", lat); end
        vectors++; if (done_cnt !== d0) begin miscompares++; $display("FAIL glitch_no_done: got %0d expected 0", done_cnt - d0); end
        $display("glitch: 10-cycle DIN low, latency=%0d, reqs=%0d", t, req_cnt - r0);
    endtask

    task automatic test_wake_handshake();
        int lat;
        vectors++; if (bus.WAKE_REQ !== 1'b1) begin miscompares++; $display("FAIL wake_outstanding: got %b expected 1", bus.WAKE_REQ); end
        bus.WAKE_ACK = 1'b1;
        @(negedge clk);
        vectors++; if (bus.WAKE_REQ !== 1'b0) begin miscompares++; $display("FAIL wake_drop_on_ack: got %b expected 0", bus.WAKE_REQ); end
        // New request while ACK still high: must be held pending.
        bus.DIN = 1'b0;
        wait_req(lat);
        vectors++; if (lat >= 40) begin miscompares++; $display("FAIL wake_req2_timeout: got no REQ_DET expected pulse"); end
        vectors++; if (bus.WAKE_REQ !== 1'b0) begin miscompares++; $display("FAIL wake_held_while_ack: got %b expected 0", bus.WAKE_REQ); end
        bus.DIN = 1'b1;
        repeat (5) @(negedge clk);
        vectors++; if (bus.WAKE_REQ !== 1'b0) begin miscompares++; $display("FAIL wake_still_held: got %b expected 0", bus.WAKE_REQ); end
        bus.WAKE_ACK = 1'b0;
        @(negedge clk);
        vectors++; if (bus.WAKE_REQ !== 1'b1) begin miscompares++; $display("FAIL wake_pending_replay: got %b expected 1", bus.WAKE_REQ); end
        bus.WAKE_ACK = 1'b1;
        @(negedge clk);
        vectors++; if (bus.WAKE_REQ !== 1'b0) begin miscompares++; $display("FAIL wake_second_ack: got %b expected 0", bus.WAKE_REQ); end
        bus.WAKE_ACK = 1'b0;
        @(negedge clk);
        vectors++; if (bus.WAKE_REQ !== 1'b0) begin miscompares++; $display("FAIL wake_no_phantom: got %b expected 0", bus.WAKE_REQ); end
        wait_not_busy(lat);
        $display("wake: ack drop, pending replay, release done (WAKE_REQ=%b)", bus.WAKE_REQ);
    endtask

    task automatic test_full_txn();
        int lat, t0, t1, d0;
        d0 = done_cnt;
        bus.DIN = 1'b0;
        wait_req(lat);
        vectors++; if (lat >= 40) begin miscompares++; $display("FAIL txn_req: got no REQ_DET expected pulse"); end
        vectors++; if (bus.EDGE_CNT !== 8'd0) begin miscompares++; $display("FAIL txn_edge_clear: got %0d expected 0", bus.EDGE_CNT); end
        vectors++; if (bus.WAKE_REQ !== 1'b1) begin miscompares++; $display("FAIL txn_wake_req: got %b expected 1", bus.WAKE_REQ); end
        clk_periods(40, 10, 10);
        vectors++; if (bus.EDGE_CNT !== 8'd40) begin miscompares++; $display("FAIL txn_edge_cnt: got %0d expected 40", bus.EDGE_CNT); end
        bus.DIN = 1'b1;
        wait_din_f_high(lat);
        t0 = cyc;
        wait_done(lat);
        t1 = cyc;
        // The edge-carrying cycle is followed by 64 idle cycles, then the pulse.
        vectors++; if (t1 - t0 !== 65) begin miscompares++; $display("FAIL txn_done_timing: got %0d expected 65", t1 - t0); end
        vectors++; if (bus.BUS_BUSY !== 1'b1) begin miscompares++; $display("FAIL busy_at_done: got %b expected 1", bus.BUS_BUSY); end
        @(negedge clk);
        vectors++; if (bus.TXN_DONE !== 1'b0) begin miscompares++; $display("FAIL txn_done_one_cycle: got %b expected 0", bus.TXN_DONE); end
        vectors++; if (bus.BUS_BUSY !== 1'b0) begin miscompares++; $display("FAIL busy_after_done: got %b expected 0", bus.BUS_BUSY); end
        repeat (20) @(negedge clk);
        vectors++; if (bus.EDGE_CNT !== 8'd40) begin miscompares++; $display("FAIL txn_edge_hold: got %0d expected 40", bus.EDGE_CNT); end
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL txn_done_count: got %0d expected 1", done_cnt - d0); end
        $display("txn: 40 CLKIN periods, EDGE_CNT=%0d, done after %0d cycles", bus.EDGE_CNT, t1 - t0);
    endtask

    task automatic test_saturation();
        int lat;
        bus.DIN = 1'b0;
        wait_req(lat);
        vectors++; if (lat >= 40) begin miscompares++; $display("FAIL sat_req: got no REQ_DET expected pulse"); end
        clk_periods(200, 5, 5);
        vectors++; if (bus.EDGE_CNT !== 8'd200) begin miscompares++; $display("FAIL sat_edge_200: got %0d expected 200", bus.EDGE_CNT); end
        clk_periods(100, 5, 5);
        vectors++; if (bus.EDGE_CNT !== 8'd255) begin miscompares++; $display("FAIL sat_edge_300: got %0d expected 255", bus.EDGE_CNT); end
        bus.DIN = 1'b1;
        wait_done(lat);
        vectors++; if (lat >= 200) begin miscompares++; $display("FAIL sat_done: got no TXN_DONE expected pulse"); end
        vectors++; if (bus.EDGE_CNT !== 8'd255) begin miscompares++; $display("FAIL sat_edge_hold: got %0d expected 255", bus.EDGE_CNT); end
        @(negedge clk);
        $display("saturation: 300 CLKIN falls, EDGE_CNT=%0d", bus.EDGE_CNT);
    endtask

    task automatic test_spurious();
        int lat, t0, t1, d0;
        d0 = done_cnt;
        bus.DIN = 1'b0;
        wait_req(lat);
        vectors++; if (lat >= 40) begin miscompares++; $display("FAIL spur_req: got no REQ_DET expected pulse"); end
        bus.DIN = 1'b1;
        wait_din_f_high(lat);
        t0 = cyc;
        wait_not_busy(lat);
        t1 = cyc;
        // 64 idle cycles end ARB, BUS_BUSY follows one register later.
        vectors++; if (t1 - t0 !== 66) begin miscompares++; $display("FAIL spur_idle_timing: got %0d expected 66", t1 - t0); end
        vectors++; if (done_cnt !== d0) begin miscompares++; $display("FAIL spur_no_done: got %0d expected 0", done_cnt - d0); end
        $display("spurious: back to idle after %0d cycles, done pulses=%0d", t1 - t0, done_cnt - d0);
    endtask

    task automatic test_en_drop();
        int lat, d0, r0;
        d0 = done_cnt;
        bus.DIN = 1'b0;
        wait_req(lat);
        vectors++; if (lat >= 40) begin miscompares++; $display("FAIL en_req: got no REQ_DET expected pulse"); end
        clk_periods(3, 5, 5);
        vectors++; if (bus.BUS_BUSY !== 1'b1) begin miscompares++; $display("FAIL en_busy_active: got %b expected 1", bus.BUS_BUSY); end
        bus.EN = 1'b0;
        r0 = req_cnt;
        repeat (2) @(negedge clk);
        vectors++; if (bus.BUS_BUSY !== 1'b0) begin miscompares++; $display("FAIL en_busy_drop: got %b expected 0", bus.BUS_BUSY); end
        vectors++; if (bus.EDGE_CNT !== 8'd3) begin miscompares++; $display("FAIL en_edge_hold: got %0d expected 3", bus.EDGE_CNT); end
        clk_periods(2, 5, 5);
        vectors++; if (bus.EDGE_CNT !== 8'd3) begin miscompares++; $display("FAIL en_edge_frozen: got %0d expected 3", bus.EDGE_CNT); end
        bus.DIN = 1'b1;
        repeat (10) @(negedge clk);
        bus.DIN = 1'b0;
        repeat (15) @(negedge clk);
        bus.DIN = 1'b1;
        repeat (100) @(negedge clk);
        vectors++; if (req_cnt !== r0) begin miscompares++; $display("FAIL en_no_req: got %0d expected 0", req_cnt - r0); end
        vectors++; if (done_cnt !== d0) begin miscompares++; $display("FAIL en_no_done: got %0d expected 0", done_cnt - d0); end
        bus.EN = 1'b1;
        repeat (10) @(negedge clk);
        vectors++; if (bus.BUS_BUSY !== 1'b0) begin miscompares++; $display("FAIL en_restore_idle: got %b expected 0", bus.BUS_BUSY); end
        $display("en: dropped in ACTIVE, EDGE_CNT=%0d held, done pulses=%0d", bus.EDGE_CNT, done_cnt - d0);
    endtask

    task automatic test_reset_mid();
        int lat, d0;
        bus.DIN = 1'b0;
        wait_req(lat);
        vectors++; if (lat >= 40) begin miscompares++; $display("FAIL rst_req: got no REQ_DET expected pulse"); end
        clk_periods(3, 5, 5);
        vectors++; if (bus.BUS_BUSY !== 1'b1) begin miscompares++; $display("FAIL rst_busy_active: got %b expected 1", bus.BUS_BUSY); end
        d0 = done_cnt;
        resetn = 1'b0;
        @(negedge clk);
        vectors++; if (bus.DIN_F !== 1'b1) begin miscompares++; $display("FAIL rst_mid_din_f: got %b expected 1", bus.DIN_F); end
        vectors++; if (bus.CLKIN_F !== 1'b1) begin miscompares++; $display("FAIL rst_mid_clkin_f: got %b expected 1", bus.CLKIN_F); end
        vectors++; if (bus.REQ_DET !== 1'b0) begin miscompares++; $display("FAIL rst_mid_req: got %b expected 0", bus.REQ_DET); end
        vectors++; if (bus.TXN_DONE !== 1'b0) begin miscompares++; $display("FAIL rst_mid_done: got %b expected 0", bus.TXN_DONE); end
        vectors++; if (bus.BUS_BUSY !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b expected 0", bus.BUS_BUSY); end
        vectors++; if (bus.EDGE_CNT !== 8'd0) begin miscompares++; $display("FAIL rst_mid_edge: got %0d expected 0", bus.EDGE_CNT); end
        vectors++; if (bus.WAKE_REQ !== 1'b0) begin miscompares++; $display("FAIL rst_mid_wake: got %b expected 0", bus.WAKE_REQ); end
        bus.DIN = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        repeat (100) @(negedge clk);
        vectors++; if (done_cnt !== d0) begin miscompares++; $display("FAIL rst_mid_no_done: got %0d expected 0", done_cnt - d0); end
        vectors++; if (bus.BUS_BUSY !== 1'b0) begin miscompares++; $display("FAIL rst_mid_idle: got %b expected 0", bus.BUS_BUSY); end
        $display("reset mid-transaction: outputs cleared, done pulses=%0d", done_cnt - d0);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_wake_handshake();
        test_full_txn();
        test_saturation();
        test_spurious();
        test_en_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
